// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: transfer size encodings, ext_tran FSM states
// and Wishbone byte-select constants used by the master and the LSU.
package soc_bus_pkg;

    localparam logic [1:0] EXT_SIZE_BYTE = 2'd0;
    localparam logic [1:0] EXT_SIZE_HALF = 2'd1;
    localparam logic [1:0] EXT_SIZE_WORD = 2'd2;

    localparam logic [3:0] WB_SEL_NONE = 4'b0000;
    localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
    localparam logic [3:0] WB_SEL_HALF = 4'b0011;
    localparam logic [3:0] WB_SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ext_tran_state_e;

endpackage

// File: rtl/ext_tran_align.sv
// Byte-lane alignment rules for a 32-bit Wishbone bus: lane select, write
// data placement, read data realignment/zero-extension and legality check.
module ext_tran_align
    import soc_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] rd_data_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wr_data_o,
    output logic [31:0] rd_data_o,
    output logic        illegal_o
);

    logic [4:0]  lane_sh;
    logic [31:0] rd_shift;

    assign lane_sh   = {a_i, 3'b000};
    assign wr_data_o = wr_data_i << lane_sh;
    assign rd_shift  = rd_data_i >> lane_sh;

    // Per-size lane select, read mask and misalignment detection
    always_comb begin
        sel_o     = WB_SEL_NONE;
        rd_data_o = 32'h0;
        illegal_o = 1'b0;
        case (size_i)
            EXT_SIZE_BYTE: begin
                sel_o     = WB_SEL_BYTE << a_i;
                rd_data_o = {24'h0, rd_shift[7:0]};
            end
            EXT_SIZE_HALF: begin
                sel_o     = WB_SEL_HALF << a_i;
                rd_data_o = {16'h0, rd_shift[15:0]};
                illegal_o = a_i[0];
            end
            EXT_SIZE_WORD: begin
                sel_o     = WB_SEL_WORD;
                rd_data_o = rd_shift;
                illegal_o = (a_i != 2'b00);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ext_tran_master.sv
// Single-transaction Wishbone classic master driven by the host bridge's
// ext_tran_* lines. Holds the FSM, request latches, timeout and status.
module ext_tran_master
    import soc_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ext_tran_start_i,
    input  logic        ext_tran_write_i,
    input  logic        ext_tran_clear_i,
    input  logic [31:0] ext_tran_addr_i,
    input  logic [31:0] ext_tran_data_i,
    input  logic [1:0]  ext_tran_size_i,
    output logic [31:0] ext_tran_data_o,
    output logic        ext_tran_ready_o,
    output logic        ext_tran_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ext_tran_state_e state_q, state_d;
    logic [31:2]     adr_q, adr_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic            busy;
    logic            timeout;
    logic [1:0]      al_size, al_a;
    logic [3:0]      al_sel;
    logic [31:0]     al_wdat, al_rdat;
    logic            al_illegal;

    assign busy    = (state_q == ST_BUSY);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    // One aligner serves both phases: the incoming request while idle (legality,
    // lane select, write placement) and the latched request while busy (read realign).
    always_comb begin
        al_size = busy ? size_q : ext_tran_size_i;
        al_a    = busy ? a_q    : ext_tran_addr_i[1:0];
    end

    ext_tran_align u_align (
        .size_i    (al_size),
        .a_i       (al_a),
        .wr_data_i (ext_tran_data_i),
        .rd_data_i (wb_dat_i),
        .sel_o     (al_sel),
        .wr_data_o (al_wdat),
        .rd_data_o (al_rdat),
        .illegal_o (al_illegal)
    );

    // Next-state: request acceptance, bus termination, timeout and status update
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        size_d  = size_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ready_d = ready_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Clear first so a same-cycle start still gets accepted on top of it
                if (ext_tran_clear_i) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    data_d  = 32'h0;
                    state_d = ST_IDLE;
                end
                if (ext_tran_start_i) begin
                    data_d = 32'h0;
                    if (al_illegal) begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        adr_d   = ext_tran_addr_i[31:2];
                        wdat_d  = al_wdat;
                        sel_d   = al_sel;
                        we_d    = ext_tran_write_i;
                        size_d  = ext_tran_size_i;
                        a_d     = ext_tran_addr_i[1:0];
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        err_d   = 1'b0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // err dominates ack; ack dominates a same-cycle timeout
                if (wb_err_i) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = ST_DONE;
                end else if (wb_ack_i) begin
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    data_d  = we_q ? 32'h0 : al_rdat;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset abandons any bus cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            size_q  <= size_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign wb_cyc_o         = busy;
    assign wb_stb_o         = busy;
    assign wb_adr_o         = {adr_q, 2'b00};
    assign wb_dat_o         = wdat_q;
    assign wb_sel_o         = sel_q;
    assign wb_we_o          = we_q;
    assign ext_tran_data_o  = data_q;
    assign ext_tran_ready_o = ready_q;
    assign ext_tran_err_o   = err_q;

endmodule
